fc_layer_scheduler: RTL and testbench
=====================================

FC_LAYER_SCHEDULER -- requirements
Module: fc_layer_scheduler

Interface
REQ-001 SHALL have parameters: CNT_BIT, default 31, width of the per-job element count; JW, default 4, job-index width (max 2^JW jobs); DWIDTH, default 32, result word width.
REQ-002 SHALL have port clk  input  1  clock, rising-edge active.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_start  input  1  start pulse; sampled only in IDLE.
REQ-005 SHALL have port i_num_jobs  input  JW+1  number of data-mover runs, legal range 1..2^JW.
REQ-006 SHALL have port i_num_cnt  input  CNT_BIT  elements per run, forwarded to the data mover.
REQ-007 SHALL have port i_abort  input  1  stop after the current run, level-sampled.
REQ-008 SHALL have port o_idle  output  1  scheduler in IDLE.
REQ-009 SHALL have port o_busy  output  1  scheduler in neither IDLE nor DONE.
REQ-010 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port o_err  output  1  one-cycle illegal-configuration pulse.
REQ-012 SHALL have port o_job_idx  output  JW  index of the current job.
REQ-013 SHALL have port o_dm_run  output  1  one-cycle run pulse to the data mover.
REQ-014 SHALL have port o_dm_num_cnt  output  CNT_BIT  latched count to the data mover.
REQ-015 SHALL have port i_dm_idle  input  1  data mover idle.
REQ-016 SHALL have port i_dm_done  input  1  data mover done pulse.
REQ-017 SHALL have ports i_dm_result_0 .. i_dm_result_3  input  DWIDTH each  outputs of the four cores.
REQ-018 SHALL have port o_res_we  output  1  result-buffer write enable.
REQ-019 SHALL have port o_res_addr  output  JW+2  result-buffer address.
REQ-020 SHALL have port o_res_data  output  DWIDTH  result-buffer write data.

Function
REQ-021 SHALL implement the states IDLE, LAUNCH, WAIT, STORE, DRAIN and DONE.
REQ-022 SHALL, in IDLE with i_start=1 and a legal configuration, latch i_num_jobs and i_num_cnt, clear o_job_idx and enter LAUNCH on the next cycle.
REQ-023 SHALL treat i_num_jobs=0, i_num_jobs>2^JW or i_num_cnt=0 as illegal at start: pulse o_err for 1 cycle, remain in IDLE, latch nothing and issue no o_dm_run.
REQ-024 SHALL ignore i_start in every state other than IDLE.
REQ-025 SHALL, in LAUNCH, assert o_dm_run for exactly 1 cycle when i_dm_idle=1, then enter WAIT; while i_dm_idle=0 it SHALL hold in LAUNCH with o_dm_run=0.
REQ-026 SHALL drive o_dm_num_cnt from the latched count and hold it constant from start until DONE.
REQ-027 SHALL, in WAIT, capture i_dm_result_0..3 into internal registers on the cycle where i_dm_done=1, then enter STORE.
REQ-028 SHALL, in STORE, write for exactly 4 consecutive cycles with o_res_we=1, o_res_addr={o_job_idx,k} and o_res_data=captured result k, for k=0,1,2,3 in order.
REQ-029 SHALL, after STORE, enter DONE if o_job_idx = latched jobs-1; otherwise it SHALL enter DRAIN if abort is pending, else increment o_job_idx and enter LAUNCH.
REQ-030 SHALL register i_abort=1 seen in LAUNCH, WAIT or STORE as a pending abort.
REQ-031 SHALL, on an abort seen in LAUNCH before o_dm_run has been issued, enter DRAIN directly with no run issued.
REQ-032 SHALL, on an abort in WAIT, still complete the current run and its STORE.
REQ-033 SHALL, in DRAIN, wait for i_dm_idle=1, then enter DONE.
REQ-034 SHALL, in DONE, pulse o_done for 1 cycle, clear the pending abort and return to IDLE.
REQ-035 SHALL ignore i_dm_done outside WAIT.
REQ-036 SHALL, for a back-to-back job, issue its o_dm_run no earlier than 1 cycle after the last STORE write.
REQ-037 SHALL make o_done follow the last i_dm_done by exactly 6 cycles when no abort is pending: 4 STORE cycles, then 1 transition cycle, then DONE.

Reset
REQ-038 SHALL, on reset_n=0, asynchronously force state IDLE, o_idle=1, all other outputs 0, o_job_idx=0, all latched counts and captured results 0, and the pending abort cleared.
REQ-039 SHALL, on reset asserted mid-run, suppress any further o_dm_run or o_res_we; the data mover shares reset_n.

Verification
REQ-040 SHALL verify a single job: i_num_jobs=1, i_num_cnt=8, results 0x11/0x22/0x33/0x44 at i_dm_done -> exactly 1 o_dm_run, writes to addr 0..3 with 0x11..0x44, o_done 6 cycles after i_dm_done.
REQ-041 SHALL verify multiple jobs: i_num_jobs=3 -> 3 o_dm_run pulses, 12 writes at addr 0..11, o_job_idx sequencing 0,1,2, and 1 o_done.
REQ-042 SHALL verify illegal configurations: i_num_cnt=0 or i_num_jobs=0 -> o_err pulse, o_dm_run never asserted, o_idle stays 1.
REQ-043 SHALL verify busy-mover stall: i_dm_idle=0 for 5 cycles in LAUNCH -> o_dm_run delayed until i_dm_idle=1, and still a single pulse.
REQ-044 SHALL verify abort: i_abort during job 1 of 4 -> job 1 stored (addr 4..7), no job 2 run, o_done after i_dm_idle=1.
REQ-045 SHALL verify reset mid-WAIT: outputs reset as REQ-038, and a new i_start afterwards runs normally from job 0.

Source files
------------

// File: rtl/fc_layer_scheduler.sv
// Fully-connected layer scheduler: issues one data-mover run per job and writes the
// four core results of each run into the result buffer at {job, core}.
module fc_layer_scheduler #(
    parameter int CNT_BIT = 31,
    parameter int JW      = 4,
    parameter int DWIDTH  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic [JW:0]        i_num_jobs,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    input  logic               i_abort,
    output logic               o_idle,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [JW-1:0]      o_job_idx,
    output logic               o_dm_run,
    output logic [CNT_BIT-1:0] o_dm_num_cnt,
    input  logic               i_dm_idle,
    input  logic               i_dm_done,
    input  logic [DWIDTH-1:0]  i_dm_result_0,
    input  logic [DWIDTH-1:0]  i_dm_result_1,
    input  logic [DWIDTH-1:0]  i_dm_result_2,
    input  logic [DWIDTH-1:0]  i_dm_result_3,
    output logic               o_res_we,
    output logic [JW+1:0]      o_res_addr,
    output logic [DWIDTH-1:0]  o_res_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_STORE  = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [JW:0] MAX_JOBS = {1'b1, {JW{1'b0}}};

    state_t                  state;
    state_t                  state_nx;
    logic [JW:0]             jobs_q;
    logic [CNT_BIT-1:0]      cnt_q;
    logic [JW-1:0]           job_idx;
    logic [1:0]              k_q;
    logic                    abort_q;
    logic [3:0][DWIDTH-1:0]  res_q;
    logic                    cfg_ok;
    logic [JW:0]             last_idx;
    logic                    last_job;
    logic                    dm_run;

    assign cfg_ok   = (i_num_jobs != '0) && (i_num_jobs <= MAX_JOBS) && (i_num_cnt != '0);
    assign last_idx = jobs_q - (JW+1)'(1);
    assign last_job = ({1'b0, job_idx} == last_idx);

    // Handshake: o_dm_run is a single-cycle request raised only while i_dm_idle=1;
    // i_dm_done is a single-cycle completion that is only honoured in WAIT.
    always_comb begin
        state_nx = state;
        dm_run   = 1'b0;
        case (state)
            S_IDLE:   if (i_start && cfg_ok) state_nx = S_LAUNCH;
            S_LAUNCH: begin
                if (i_abort) begin
                    state_nx = S_DRAIN;
                end else if (i_dm_idle) begin
                    dm_run   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT:   if (i_dm_done) state_nx = S_STORE;
            S_STORE: begin
                if (k_q == 2'd3) begin
                    if (last_job)                state_nx = S_DONE;
                    else if (abort_q || i_abort) state_nx = S_DRAIN;
                    else                         state_nx = S_LAUNCH;
                end
            end
            S_DRAIN:  if (i_dm_idle) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            jobs_q  <= '0;
            cnt_q   <= '0;
            job_idx <= '0;
            k_q     <= '0;
            abort_q <= 1'b0;
            res_q   <= '0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state  <= state_nx;
            o_done <= (state == S_DONE);
            o_err  <= (state == S_IDLE) && i_start && !cfg_ok;
            if (state == S_IDLE && i_start && cfg_ok) begin
                jobs_q  <= i_num_jobs;
                cnt_q   <= i_num_cnt;
                job_idx <= '0;
                abort_q <= 1'b0;
            end
            if ((state == S_LAUNCH || state == S_WAIT || state == S_STORE) && i_abort)
                abort_q <= 1'b1;
            else if (state == S_DONE)
                abort_q <= 1'b0;
            if (state == S_WAIT && i_dm_done) begin
                res_q <= {i_dm_result_3, i_dm_result_2, i_dm_result_1, i_dm_result_0};
                k_q   <= '0;
            end
            if (state == S_STORE) begin
                k_q <= k_q + 2'd1;
                if (state_nx == S_LAUNCH) job_idx <= job_idx + JW'(1);
            end
        end
    end

    assign o_idle       = (state == S_IDLE);
    assign o_busy       = (state != S_IDLE) && (state != S_DONE);
    assign o_job_idx    = job_idx;
    assign o_dm_run     = dm_run;
    assign o_dm_num_cnt = cnt_q;
    assign o_res_we     = (state == S_STORE);
    assign o_res_addr   = o_res_we ? {job_idx, k_q} : '0;
    assign o_res_data   = o_res_we ? res_q[k_q] : '0;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Bench for fc_layer_scheduler: a reactive data-mover model plus a job-level
// reference model that predicts runs, result writes and completion timing.
module tb_fc_layer_scheduler;

    localparam int CNT_BIT = 31;
    localparam int JW      = 4;
    localparam int DWIDTH  = 32;
    localparam int MAXJ    = 1 << JW;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               i_start = 1'b0;
    logic [JW:0]        i_num_jobs = '0;
    logic [CNT_BIT-1:0] i_num_cnt = '0;
    logic               i_abort = 1'b0;
    logic               o_idle, o_busy, o_done, o_err;
    logic [JW-1:0]      o_job_idx;
    logic               o_dm_run;
    logic [CNT_BIT-1:0] o_dm_num_cnt;
    logic               i_dm_idle = 1'b1;
    logic               i_dm_done = 1'b0;
    logic [DWIDTH-1:0]  i_dm_result_0 = '0, i_dm_result_1 = '0, i_dm_result_2 = '0, i_dm_result_3 = '0;
    logic               o_res_we;
    logic [JW+1:0]      o_res_addr;
    logic [DWIDTH-1:0]  o_res_data;

    fc_layer_scheduler #(.CNT_BIT(CNT_BIT), .JW(JW), .DWIDTH(DWIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_num_jobs(i_num_jobs),
        .i_num_cnt(i_num_cnt), .i_abort(i_abort), .o_idle(o_idle), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_job_idx(o_job_idx), .o_dm_run(o_dm_run),
        .o_dm_num_cnt(o_dm_num_cnt), .i_dm_idle(i_dm_idle), .i_dm_done(i_dm_done),
        .i_dm_result_0(i_dm_result_0), .i_dm_result_1(i_dm_result_1),
        .i_dm_result_2(i_dm_result_2), .i_dm_result_3(i_dm_result_3),
        .o_res_we(o_res_we), .o_res_addr(o_res_addr), .o_res_data(o_res_data)
    );

    // clock / reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // monitor: sampled on the falling edge, away from the active edge
    int                 run_cnt = 0, done_cnt = 0, err_cnt = 0, nidle_cnt = 0;
    int                 bad_run = 0, cnt_bad = 0, done_cyc = 0, dmdone_cyc = 0;
    logic [JW-1:0]      run_idx_q[$];
    int                 run_cyc_q[$];
    logic [JW+1:0]      wr_addr_q[$];
    logic [DWIDTH-1:0]  wr_data_q[$];
    logic [CNT_BIT-1:0] cur_cnt = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (o_dm_run) begin
                run_cnt++;
                run_idx_q.push_back(o_job_idx);
                run_cyc_q.push_back(cyc);
                if (!i_dm_idle) bad_run++;
            end
            if (o_res_we) begin
                wr_addr_q.push_back(o_res_addr);
                wr_data_q.push_back(o_res_data);
            end
            if (i_dm_done) dmdone_cyc = cyc;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_err) err_cnt++;
            if (!o_idle) nidle_cnt++;
            if (o_busy && o_dm_num_cnt !== cur_cnt) cnt_bad++;
        end
    end

    // data-mover model: random latency, garbage results except on the done cycle
    logic [DWIDTH-1:0] res_tab [MAXJ][4];
    int mv_handled = 0, mv_left = 0, mv_job = 0, hold_until = 0;
    bit mv_busy = 1'b0;

    always begin
        @(posedge clk);
        #1;
        i_dm_done     = 1'b0;
        i_dm_result_0 = $urandom;
        i_dm_result_1 = $urandom;
        i_dm_result_2 = $urandom;
        i_dm_result_3 = $urandom;
        if (!reset_n) begin
            mv_busy    = 1'b0;
            mv_handled = run_cnt;
        end else if (mv_busy) begin
            mv_left--;
            if (mv_left == 0) begin
                i_dm_done     = 1'b1;
                i_dm_result_0 = res_tab[mv_job][0];
                i_dm_result_1 = res_tab[mv_job][1];
                i_dm_result_2 = res_tab[mv_job][2];
                i_dm_result_3 = res_tab[mv_job][3];
                mv_busy       = 1'b0;
            end
        end else if (run_cnt > mv_handled) begin
            mv_job  = int'(run_idx_q[mv_handled]);
            mv_handled++;
            mv_busy = 1'b1;
            mv_left = $urandom_range(1, 4);
        end
        i_dm_idle = !mv_busy && (cyc >= hold_until);
    end

    task automatic check_reset(input string p);
        check({p, "_idle"}, o_idle, 1);
        check({p, "_busy"}, o_busy, 0);
        check({p, "_done"}, o_done, 0);
        check({p, "_err"}, o_err, 0);
        check({p, "_job_idx"}, o_job_idx, 0);
        check({p, "_dm_run"}, o_dm_run, 0);
        check({p, "_dm_num_cnt"}, o_dm_num_cnt, 0);
        check({p, "_res_we"}, o_res_we, 0);
        check({p, "_res_addr"}, o_res_addr, 0);
        check({p, "_res_data"}, o_res_data, 0);
    endtask

    // driver: one layer; the reference model predicts it at job granularity
    task automatic run_test(input int jobs, input int cnt, input int hold, input int abort_job,
                            input bit abort_launch, input bit fixed_res);
        int run_base, wr_base, done_base, bad_base, cb_base, start_cyc, last_j, n_runs, waited;
        logic [JW+1:0]     exp_addr_q[$];
        logic [DWIDTH-1:0] exp_data_q[$];
        for (int j = 0; j < MAXJ; j++)
            for (int k = 0; k < 4; k++)
                res_tab[j][k] = fixed_res ? DWIDTH'(32'h11 * (k + 1)) : DWIDTH'($urandom);
        run_base  = run_cnt;
        wr_base   = wr_addr_q.size();
        done_base = done_cnt;
        bad_base  = bad_run;
        cb_base   = cnt_bad;

        @(posedge clk); #2;
        i_num_jobs = (JW+1)'(jobs);
        i_num_cnt  = CNT_BIT'(cnt);
        cur_cnt    = CNT_BIT'(cnt);
        i_start    = 1'b1;
        start_cyc  = cyc;
        hold_until = cyc + hold;
        @(posedge clk); #2;
        i_start    = 1'b0;
        i_num_jobs = (JW+1)'(1);
        i_num_cnt  = CNT_BIT'(cnt + 3);
        @(posedge clk); #2;
        if (abort_launch) i_abort = 1'b1;
        else              i_start = 1'b1;
        @(posedge clk); #2;
        i_abort = 1'b0;
        i_start = 1'b0;

        if (abort_job >= 1 && !abort_launch) begin
            for (waited = 0; waited < 1000 && run_cnt - run_base < abort_job + 1; waited++) begin
                @(posedge clk); #2;
            end
            i_abort = 1'b1;
            @(posedge clk); #2;
            i_abort = 1'b0;
        end
        for (waited = 0; waited < 3000 && done_cnt == done_base; waited++) begin
            @(posedge clk); #2;
        end
        repeat (3) @(posedge clk);
        #2;

        if (abort_launch)                             last_j = -1;
        else if (abort_job >= 1 && abort_job < jobs - 1) last_j = abort_job;
        else                                          last_j = jobs - 1;
        n_runs = last_j + 1;
        for (int j = 0; j <= last_j; j++)
            for (int k = 0; k < 4; k++) begin
                exp_addr_q.push_back((JW+2)'(j * 4 + k));
                exp_data_q.push_back(res_tab[j][k]);
            end

        check("done_count", done_cnt - done_base, 1);
        check("run_count", run_cnt - run_base, n_runs);
        check("write_count", wr_addr_q.size() - wr_base, exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size(); i++)
            if (wr_base + i < wr_addr_q.size()) begin
                check("res_addr", wr_addr_q[wr_base + i], exp_addr_q[i]);
                check("res_data", wr_data_q[wr_base + i], exp_data_q[i]);
            end
        for (int i = 0; i < n_runs; i++)
            if (run_base + i < run_idx_q.size())
                check("job_idx_seq", run_idx_q[run_base + i], i);
        if (n_runs > 0 && run_base < run_cyc_q.size())
            check("first_run_delay", run_cyc_q[run_base] - start_cyc, (hold > 1) ? hold : 1);
        if (abort_launch)
            check("done_delay_launch_abort", done_cyc - start_cyc, 8);
        else
            check("done_after_dm_done", done_cyc - dmdone_cyc, (last_j < jobs - 1) ? 7 : 6);
        check("run_while_mover_busy", bad_run - bad_base, 0);
        check("num_cnt_held", cnt_bad - cb_base, 0);
        check("idle_after_done", o_idle, 1);
    endtask

    task automatic illegal(input int jobs, input int cnt, input string tag);
        int err_base, run_base, ni_base;
        err_base = err_cnt;
        run_base = run_cnt;
        ni_base  = nidle_cnt;
        @(posedge clk); #2;
        i_num_jobs = (JW+1)'(jobs);
        i_num_cnt  = CNT_BIT'(cnt);
        i_start    = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_err_pulse"}, err_cnt - err_base, 1);
        check({tag, "_no_run"}, run_cnt - run_base, 0);
        check({tag, "_stay_idle"}, nidle_cnt - ni_base, 0);
        check({tag, "_cnt_unlatched"}, o_dm_num_cnt, cur_cnt);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_base, wr_base, waited, jobs, abort_job;
        #1 reset_n = 1'b0;
        #1 check_reset("por");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        run_test(1, 8, 0, -1, 1'b0, 1'b1);
        run_test(3, 20, 0, -1, 1'b0, 1'b0);
        illegal(2, 0, "cnt_zero");
        illegal(0, 5, "jobs_zero");
        illegal(MAXJ + 1, 5, "jobs_over");
        run_test(2, 9, 6, -1, 1'b0, 1'b0);
        run_test(4, 12, 0, 1, 1'b0, 1'b0);
        run_test(3, 7, 6, -1, 1'b1, 1'b0);
        run_test(MAXJ, 3, 0, -1, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            jobs = $urandom_range(1, 8);
            abort_job = (jobs > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, jobs - 2) : -1;
            run_test(jobs, $urandom_range(1, 1000), ($urandom_range(0, 1) == 1) ? 6 : 0,
                     abort_job, 1'b0, 1'b0);
        end

        // reset while the first run is outstanding
        run_base = run_cnt;
        wr_base  = wr_addr_q.size();
        @(posedge clk); #2;
        i_num_jobs = (JW+1)'(3);
        i_num_cnt  = CNT_BIT'(40);
        cur_cnt    = CNT_BIT'(40);
        i_start    = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        for (waited = 0; waited < 200 && run_cnt == run_base; waited++) begin
            @(posedge clk); #2;
        end
        reset_n = 1'b0;
        #1 check_reset("mid_wait");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("reset_runs", run_cnt - run_base, 1);
        check("reset_no_writes", wr_addr_q.size() - wr_base, 0);
        run_test(2, 15, 0, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
